// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler sharing one resource among 8 requesters with held grants,
// a hold timeout and a two-digit seven-segment owner/status display.
module rr_grant_scheduler #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       release_owner,
  output logic [7:0] grant,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout,
  output logic [7:0] switch_led,
  output logic [7:0] a_to_g_left,
  output logic [7:0] a_to_g_right
);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_t;

  localparam logic [7:0] SEG_E     = 8'b10011110;
  localparam logic [7:0] SEG_DP    = 8'b00000001;
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  function automatic logic [7:0] seg7(input logic [2:0] idx);
    logic [7:0] seg;
    case (idx)
      3'd0:    seg = 8'b11111100;
      3'd1:    seg = 8'b01100000;
      3'd2:    seg = 8'b11011010;
      3'd3:    seg = 8'b11110010;
      3'd4:    seg = 8'b01100110;
      3'd5:    seg = 8'b10110110;
      3'd6:    seg = 8'b10111110;
      3'd7:    seg = 8'b11100000;
      default: seg = 8'b00000000;
    endcase
    return seg;
  endfunction

  state_t     state_r, state_n;
  logic [2:0] last_r, last_n;
  logic [7:0] hold_r, hold_n;
  logic [7:0] grant_r, grant_n;
  logic [2:0] idx_r, idx_n;
  logic       valid_r, valid_n;
  logic       timeout_r, timeout_n;
  logic [7:0] led_r, led_n;
  logic [7:0] left_r, left_n;
  logic [7:0] right_r, right_n;

  logic       found_s;
  logic [2:0] win_s;
  logic [2:0] cand_s;
  logic       hit_s;
  logic       owner_done_s;
  logic       expire_s;

  // A dropped request ends the grant exactly like an explicit release.
  assign owner_done_s = release_owner | ~req[idx_r];
  assign expire_s     = (hold_r == HOLD_LAST);

  // Round-robin search starting one past the previous winner, wrapping upward.
  always_comb begin
    found_s = 1'b0;
    win_s   = 3'd0;
    cand_s  = 3'd0;
    hit_s   = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cand_s  = last_r + i[2:0];
      hit_s   = ~found_s & req[cand_s];
      win_s   = hit_s ? cand_s : win_s;
      found_s = found_s | hit_s;
    end
  end

  // Next-state and next-output logic for the IDLE/GRANT/GAP sequence.
  always_comb begin
    state_n   = state_r;
    last_n    = last_r;
    hold_n    = hold_r;
    grant_n   = grant_r;
    idx_n     = idx_r;
    valid_n   = valid_r;
    timeout_n = 1'b0;
    led_n     = led_r;
    left_n    = left_r;
    right_n   = right_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_n = GRANT;
          grant_n = 8'b00000001 << win_s;
          led_n   = 8'b00000001 << win_s;
          idx_n   = win_s;
          last_n  = win_s;
          hold_n  = 8'd0;
          valid_n = 1'b1;
          left_n  = seg7(win_s);
          right_n = SEG_DP;
        end else begin
          state_n = IDLE;
        end
      end
      GRANT: begin
        if (owner_done_s || expire_s) begin
          state_n   = GAP;
          grant_n   = 8'd0;
          led_n     = 8'd0;
          valid_n   = 1'b0;
          right_n   = SEG_E;
          timeout_n = expire_s & ~owner_done_s;
        end else begin
          hold_n = hold_r + 8'd1;
        end
      end
      GAP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        grant_n = 8'd0;
        led_n   = 8'd0;
        valid_n = 1'b0;
        right_n = SEG_E;
      end
    endcase
  end

  // State and registered outputs; reset blanks the left digit until the first grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      last_r    <= 3'd7;
      hold_r    <= 8'd0;
      grant_r   <= 8'd0;
      idx_r     <= 3'd0;
      valid_r   <= 1'b0;
      timeout_r <= 1'b0;
      led_r     <= 8'd0;
      left_r    <= 8'd0;
      right_r   <= SEG_E;
    end else begin
      state_r   <= state_n;
      last_r    <= last_n;
      hold_r    <= hold_n;
      grant_r   <= grant_n;
      idx_r     <= idx_n;
      valid_r   <= valid_n;
      timeout_r <= timeout_n;
      led_r     <= led_n;
      left_r    <= left_n;
      right_r   <= right_n;
    end
  end

  assign grant        = grant_r;
  assign gnt_idx      = idx_r;
  assign gnt_valid    = valid_r;
  assign timeout      = timeout_r;
  assign switch_led   = led_r;
  assign a_to_g_left  = left_r;
  assign a_to_g_right = right_r;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed self-checking bench for rr_grant_scheduler (HOLD_MAX = 16).
module tb_rr_grant_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       release_owner = 1'b0;
  logic [7:0] grant;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;
  logic [7:0] switch_led;
  logic [7:0] a_to_g_left;
  logic [7:0] a_to_g_right;

  int pass_cnt = 0;
  int total_cnt = 0;

  rr_grant_scheduler #(.HOLD_MAX(16)) dut (
    .clk(clk), .rst(rst), .req(req), .release_owner(release_owner),
    .grant(grant), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout),
    .switch_led(switch_led), .a_to_g_left(a_to_g_left), .a_to_g_right(a_to_g_right)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'hFF; release_owner = 1'b0;
    cyc(); cyc();
    total_cnt++;
    if (grant !== 8'h00) $display("FAIL reset_grant: got %h want 00", grant); else pass_cnt++;
    total_cnt++;
    if (a_to_g_right !== 8'b10011110) $display("FAIL reset_right: got %b want 10011110", a_to_g_right); else pass_cnt++;
    total_cnt++;
    if (a_to_g_left !== 8'b00000000) $display("FAIL reset_left: got %b want 00000000", a_to_g_left); else pass_cnt++;
    total_cnt++;
    if ({gnt_valid, timeout, switch_led, gnt_idx} !== 13'd0) $display("FAIL reset_misc: got %b want 0", {gnt_valid, timeout, switch_led, gnt_idx}); else pass_cnt++;
    rst = 1'b0;
    cyc();
    total_cnt++;
    if (grant !== 8'h01) $display("FAIL first_grant: got %h want 01", grant); else pass_cnt++;
    total_cnt++;
    if (gnt_idx !== 3'd0 || gnt_valid !== 1'b1 || switch_led !== 8'h01) $display("FAIL first_idx: got idx %0d valid %b led %h want 0 1 01", gnt_idx, gnt_valid, switch_led); else pass_cnt++;
    total_cnt++;
    if (a_to_g_left !== 8'b11111100 || a_to_g_right !== 8'b00000001) $display("FAIL first_display: got %b %b want 11111100 00000001", a_to_g_left, a_to_g_right); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_g;
    for (int k = 1; k <= 8; k++) begin
      release_owner = 1'b1;
      cyc();
      release_owner = 1'b0;
      total_cnt++;
      if (grant !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) $display("FAIL rr_gap%0d: got grant %h valid %b to %b want 00 0 0", k, grant, gnt_valid, timeout); else pass_cnt++;
      cyc();
      total_cnt++;
      if (grant !== 8'h00 || a_to_g_right !== 8'b10011110) $display("FAIL rr_idle%0d: got grant %h right %b want 00 10011110", k, grant, a_to_g_right); else pass_cnt++;
      cyc();
      exp_g = 8'h01 << (k % 8);
      total_cnt++;
      if (grant !== exp_g || gnt_idx !== 3'(k % 8)) $display("FAIL rr_grant%0d: got %h idx %0d want %h idx %0d", k, grant, gnt_idx, exp_g, k % 8); else pass_cnt++;
    end
  endtask

  task automatic test_skip();
    req = 8'b00000100; release_owner = 1'b1;
    cyc(); release_owner = 1'b0;
    cyc(); cyc();
    total_cnt++;
    if (grant !== 8'h04) $display("FAIL skip_setup: got %h want 04", grant); else pass_cnt++;
    req = 8'b00100100; release_owner = 1'b1;
    cyc(); release_owner = 1'b0;
    cyc(); cyc();
    total_cnt++;
    if (grant !== 8'h20 || gnt_idx !== 3'd5) $display("FAIL skip_grant5: got %h idx %0d want 20 idx 5", grant, gnt_idx); else pass_cnt++;
    total_cnt++;
    if (a_to_g_left !== 8'b10110110) $display("FAIL skip_left5: got %b want 10110110", a_to_g_left); else pass_cnt++;
    release_owner = 1'b1;
    cyc(); release_owner = 1'b0;
    cyc();
    total_cnt++;
    if (a_to_g_left !== 8'b10110110 || a_to_g_right !== 8'b10011110) $display("FAIL idle_hold_left: got %b %b want 10110110 10011110", a_to_g_left, a_to_g_right); else pass_cnt++;
    cyc();
    total_cnt++;
    if (grant !== 8'h04 || a_to_g_left !== 8'b11011010) $display("FAIL skip_wrap2: got %h %b want 04 11011010", grant, a_to_g_left); else pass_cnt++;
  endtask

  task automatic test_timeout();
    req = 8'h08;
    cyc();
    total_cnt++;
    if (grant !== 8'h00 || timeout !== 1'b0) $display("FAIL drop_req: got grant %h to %b want 00 0", grant, timeout); else pass_cnt++;
    cyc(); cyc();
    total_cnt++;
    if (grant !== 8'h08) $display("FAIL to_grant3: got %h want 08", grant); else pass_cnt++;
    for (int i = 2; i <= 16; i++) begin
      cyc();
      total_cnt++;
      if (grant !== 8'h08 || timeout !== 1'b0) $display("FAIL to_hold%0d: got %h to %b want 08 0", i, grant, timeout); else pass_cnt++;
    end
    cyc();
    total_cnt++;
    if (grant !== 8'h00 || timeout !== 1'b1) $display("FAIL to_pulse: got grant %h to %b want 00 1", grant, timeout); else pass_cnt++;
    cyc();
    total_cnt++;
    if (timeout !== 1'b0 || grant !== 8'h00) $display("FAIL to_single: got to %b grant %h want 0 00", timeout, grant); else pass_cnt++;
    cyc();
    total_cnt++;
    if (grant !== 8'h08) $display("FAIL to_regrant: got %h want 08", grant); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    for (int i = 2; i <= 16; i++) cyc();
    total_cnt++;
    if (grant !== 8'h08) $display("FAIL sim_held: got %h want 08", grant); else pass_cnt++;
    release_owner = 1'b1;
    cyc(); release_owner = 1'b0;
    total_cnt++;
    if (grant !== 8'h00 || timeout !== 1'b0) $display("FAIL sim_release: got grant %h to %b want 00 0", grant, timeout); else pass_cnt++;
    cyc(); cyc();
    total_cnt++;
    if (grant !== 8'h08) $display("FAIL sim_regrant: got %h want 08", grant); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    req = 8'h40; release_owner = 1'b1;
    cyc(); release_owner = 1'b0;
    cyc(); cyc();
    total_cnt++;
    if (grant !== 8'h40 || gnt_idx !== 3'd6) $display("FAIL ar_grant6: got %h idx %0d want 40 6", grant, gnt_idx); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if (grant !== 8'h00 || gnt_valid !== 1'b0) $display("FAIL ar_drop: got %h valid %b want 00 0", grant, gnt_valid); else pass_cnt++;
    total_cnt++;
    if (a_to_g_right !== 8'b10011110) $display("FAIL ar_right: got %b want 10011110", a_to_g_right); else pass_cnt++;
    req = 8'hC0;
    cyc();
    rst = 1'b0;
    cyc();
    total_cnt++;
    if (grant !== 8'h40 || a_to_g_left !== 8'b10111110) $display("FAIL ar_after: got %h %b want 40 10111110", grant, a_to_g_left); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_skip();
    test_timeout();
    test_simultaneous();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
